// File: rtl/freq_ascii_formatter.sv
// Binary count -> sequential double-dabble -> ASCII decimal line ("<digits>\r\n") on a valid/ready byte port.
// First byte 33 edges after capture (default width); bytes hold under tx_ready_i=0, strobes outside IDLE are dropped.
module freq_ascii_formatter #(
   parameter int COUNT_WIDTH = 32,
   parameter int DIGITS      = 10
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [COUNT_WIDTH-1:0] count_i,
   input  logic                   count_valid_i,
   output logic                   busy_o,
   output logic                   drop_o,
   output logic [7:0]             tx_data_o,
   output logic                   tx_valid_o,
   input  logic                   tx_ready_i
);

   localparam int CW = $clog2(COUNT_WIDTH + 1);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BW = 4 * DIGITS;

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      LOCATE,
      SEND_DIGIT,
      SEND_CR,
      SEND_LF
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [COUNT_WIDTH-1:0] shift;
   logic [BW-1:0]          bcd;
   logic [BW-1:0]          bcd_adj;
   logic [CW-1:0]          cycle_cnt;
   logic [IW-1:0]          idx;
   logic [IW-1:0]          msd;
   logic [3:0]             digit;

   // Add-3 correction applied to every nibble before each shift.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // Highest nonzero nibble wins; all-zero leaves index 0 so "0" is printed.
   always_comb begin
      msd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] != 4'd0) begin
            msd = IW'(i);
         end
      end
   end

   always_comb begin
      digit = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            digit = bcd[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      tx_valid_o = 1'b0;
      tx_data_o  = 8'h00;
      busy_o     = (state != IDLE);
      case (state)
         IDLE: begin
            if (count_valid_i) begin
               state_nxt = CONVERT;
            end
         end
         CONVERT: begin
            if (cycle_cnt == CW'(COUNT_WIDTH - 1)) begin
               state_nxt = LOCATE;
            end
         end
         LOCATE: begin
            state_nxt = SEND_DIGIT;
         end
         SEND_DIGIT: begin
            tx_valid_o = 1'b1;
            tx_data_o  = 8'h30 + {4'h0, digit};
            if (tx_ready_i && (idx == '0)) begin
               state_nxt = SEND_CR;
            end
         end
         SEND_CR: begin
            tx_valid_o = 1'b1;
            tx_data_o  = 8'h0D;
            if (tx_ready_i) begin
               state_nxt = SEND_LF;
            end
         end
         SEND_LF: begin
            tx_valid_o = 1'b1;
            tx_data_o  = 8'h0A;
            if (tx_ready_i) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         shift     <= '0;
         bcd       <= '0;
         cycle_cnt <= '0;
         idx       <= '0;
         drop_o    <= 1'b0;
      end else begin
         drop_o <= count_valid_i && (state != IDLE);
         case (state)
            IDLE: begin
               if (count_valid_i) begin
                  shift     <= count_i;
                  bcd       <= '0;
                  cycle_cnt <= '0;
               end
            end
            CONVERT: begin
               {bcd, shift} <= {bcd_adj[BW-2:0], shift, 1'b0};
               cycle_cnt    <= cycle_cnt + CW'(1);
            end
            LOCATE: begin
               idx <= msd;
            end
            SEND_DIGIT: begin
               if (tx_ready_i && (idx != '0)) begin
                  idx <= idx - IW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_ascii_formatter.sv
// Bench for freq_ascii_formatter: table of counts plus hand sequences for drop and mid-frame reset.
module tb_freq_ascii_formatter;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [31:0] count_i = '0;
   logic        count_valid_i = 1'b0;
   logic        busy_o;
   logic        drop_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i = 1'b0;

   freq_ascii_formatter #(.COUNT_WIDTH(32), .DIGITS(10)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .count_i       (count_i),
      .count_valid_i (count_valid_i),
      .busy_o        (busy_o),
      .drop_o        (drop_o),
      .tx_data_o     (tx_data_o),
      .tx_valid_o    (tx_valid_o),
      .tx_ready_i    (tx_ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] count;
      int          len;
      int          ready_pct;
   } vec_t;

   int         total = 0;
   int         passed = 0;
   int         bytes_seen = 0;
   int         drops = 0;
   int         ready_pct = 100;
   bit         auto_ready = 1'b1;
   logic [7:0] sb[$];
   bit         stall_pending = 1'b0;
   logic [7:0] prev_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference decimal expansion by repeated division.
   task automatic push_expected(input logic [31:0] v, output int len);
      int d[$];
      logic [31:0] x;
      x = v;
      do begin
         d.push_front(int'(x % 10));
         x = x / 10;
      end while (x != 0);
      foreach (d[i]) sb.push_back(8'h30 + 8'(d[i]));
      sb.push_back(8'h0D);
      sb.push_back(8'h0A);
      len = d.size() + 2;
   endtask

   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         if (auto_ready) tx_ready_i = ($urandom_range(0, 99) < ready_pct);
      end
   end

   always @(negedge clk_i) begin
      if (stall_pending) begin
         check("stall_valid", {31'd0, tx_valid_o}, 32'd1);
         check("stall_data", {24'd0, tx_data_o}, {24'd0, prev_data});
      end
      stall_pending = rst_i && tx_valid_o && !tx_ready_i;
      prev_data = tx_data_o;
      if (rst_i && drop_o) drops++;
      if (rst_i && tx_valid_o && tx_ready_i) begin
         bytes_seen++;
         if (sb.size() == 0) begin
            check("tx_unexpected", {24'd0, tx_data_o}, 32'hFFFF_FFFF);
         end else begin
            check("tx_byte", {24'd0, tx_data_o}, {24'd0, sb.pop_front()});
         end
      end
   end

   task automatic start_capture(input logic [31:0] v, output int len);
      count_i = v;
      count_valid_i = 1'b1;
      push_expected(v, len);
      @(posedge clk_i);
      #1;
      count_valid_i = 1'b0;
   endtask

   // Counts rising edges after the capture edge until tx_valid_o is seen.
   task automatic wait_first_valid(output int n);
      bit done;
      done = 1'b0;
      n = 0;
      while (!done && n < 100) begin
         @(posedge clk_i);
         n++;
         @(negedge clk_i);
         if (tx_valid_o) done = 1'b1;
      end
      check("first_valid_latency", n, 33);
   endtask

   task automatic wait_idle(output int k);
      k = 0;
      while (busy_o && k < 3000) begin
         @(negedge clk_i);
         k++;
      end
      check("frame_done_busy", {31'd0, busy_o}, 32'd0);
      check("frame_done_valid", {31'd0, tx_valid_o}, 32'd0);
      check("sb_empty", sb.size(), 0);
   endtask

   task automatic run_frame(input vec_t v);
      int len, n, k, start;
      ready_pct = v.ready_pct;
      @(posedge clk_i);
      #1;
      start = bytes_seen;
      start_capture(v.count, len);
      check("model_len", len, v.len);
      wait_first_valid(n);
      wait_idle(k);
      check("frame_bytes", bytes_seen - start, v.len);
      if (v.ready_pct == 100) check("back_to_back_cycles", k, v.len);
   endtask

   vec_t vecs[7];

   initial begin
      int len, n, k, bound, d0;
      vecs[0] = '{32'd0,          3,  100};
      vecs[1] = '{32'd1234567,    9,  100};
      vecs[2] = '{32'hFFFF_FFFF,  12, 100};
      vecs[3] = '{32'd1000000000, 12, 100};
      vecs[4] = '{32'd907,        5,  30};
      vecs[5] = '{32'd9,          3,  100};
      vecs[6] = '{32'd10,         4,  50};

      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_drop", {31'd0, drop_o}, 32'd0);
      check("rst_valid", {31'd0, tx_valid_o}, 32'd0);
      check("rst_data", {24'd0, tx_data_o}, 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;

      foreach (vecs[i]) run_frame(vecs[i]);

      // Strobes during CONVERT and in the LF handshake cycle are dropped; next one is taken.
      ready_pct = 100;
      d0 = drops;
      @(posedge clk_i);
      #1;
      start_capture(32'd1234567, len);
      repeat (5) @(posedge clk_i);
      #1;
      count_i = 32'd99;
      count_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      count_valid_i = 1'b0;
      @(negedge clk_i);
      check("drop_convert", {31'd0, drop_o}, 32'd1);
      @(negedge clk_i);
      check("drop_pulse_width", {31'd0, drop_o}, 32'd0);
      bound = 0;
      while (!(tx_valid_o && tx_ready_i && tx_data_o == 8'h0A) && bound < 200) begin
         @(negedge clk_i);
         bound++;
      end
      check("lf_reached", {31'd0, tx_valid_o && tx_data_o == 8'h0A}, 32'd1);
      count_i = 32'd77;
      count_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      count_i = 32'd55;
      push_expected(32'd55, len);
      @(negedge clk_i);
      check("drop_lf", {31'd0, drop_o}, 32'd1);
      check("busy_after_lf", {31'd0, busy_o}, 32'd0);
      @(posedge clk_i);
      #1;
      count_valid_i = 1'b0;
      wait_first_valid(n);
      wait_idle(k);
      check("drop_total", drops - d0, 2);

      // Reset while the third digit of 4294967295 is pending.
      auto_ready = 1'b0;
      tx_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_capture(32'hFFFF_FFFF, len);
      wait_first_valid(n);
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      tx_ready_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(negedge clk_i);
      check("midrst_valid", {31'd0, tx_valid_o}, 32'd0);
      check("midrst_busy", {31'd0, busy_o}, 32'd0);
      check("midrst_data", {24'd0, tx_data_o}, 32'd0);
      check("midrst_remaining", sb.size(), 10);
      sb.delete();
      repeat (3) @(negedge clk_i);
      check("midrst_quiet", {31'd0, tx_valid_o}, 32'd0);
      auto_ready = 1'b1;
      run_frame('{32'd42, 4, 100});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
